router_pkt_tx: RTL

Source-side packet transmitter. It drives the router input port, the end of the interface that feeds the router FIFOs. Payload bytes are preloaded into an internal buffer. On start, the block emits header, payload and parity using the router framing: pkt_valid high for header and payload, parity on the next accepted cycle with pkt_valid low. The block honours router busy backpressure. It is used as the stimulus and traffic source for the 1x3 router.

---
 rtl/router_pkt_tx.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/router_pkt_tx.sv
// router_pkt_tx
// Source-side packet transmitter for the 1x3 router input port.
// Payload bytes are preloaded into a 64x8 buffer while idle. A start request
// sends the packet as header, payload and then parity:
//   header = {payload length[5:0], dest_addr[1:0]}
//   parity = XOR of the header and every payload byte
// pkt_valid is high for the header and payload bytes and low for parity.
// A presented byte is held while the router raises busy. After the parity
// byte is accepted, done pulses and the block waits PKT_GAP cycles before it
// honours another start.
//
// Optional feature (macro ROUTER_TX_BAD_PARITY_EN):
//   Adds the input corrupt_parity. It is sampled when the parity byte is
//   first presented. When it is 1, the inverted parity is sent so that the
//   router's parity-error detection can be exercised. Without the macro the
//   port does not exist and parity is always correct.
//
// Parameters:
//   PKT_GAP         idle cycles after parity acceptance (1..15)
// Ports:
//   clock           system clock, rising edge
//   resetn          asynchronous active-low reset
//   ld_en, ld_data  load strobe and payload byte (accepted in IDLE only)
//   ld_full         buffer holds 63 bytes; further loads are ignored
//   dest_addr       destination port 0..2 (3 is illegal)
//   start           send request, sampled in IDLE only
//   busy            router backpressure; the presented byte is held
//   data_out        byte driven to the router data input
//   pkt_valid       high during header and payload bytes
//   tx_active       high from the header cycle through parity acceptance
//   done            one-cycle pulse after the parity byte is accepted
//   err             one-cycle pulse on an illegal start
//   corrupt_parity  (ROUTER_TX_BAD_PARITY_EN only) invert the parity byte

module router_pkt_tx #(
    parameter int PKT_GAP = 2
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       ld_en,
    input  logic [7:0] ld_data,
    output logic       ld_full,
    input  logic [1:0] dest_addr,
    input  logic       start,
    input  logic       busy,
`ifdef ROUTER_TX_BAD_PARITY_EN
    input  logic       corrupt_parity,
`endif
    output logic [7:0] data_out,
    output logic       pkt_valid,
    output logic       tx_active,
    output logic       done,
    output logic       err
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] HDR  = 3'd1;
    localparam logic [2:0] PLD  = 3'd2;
    localparam logic [2:0] PAR  = 3'd3;
    localparam logic [2:0] GAP  = 3'd4;

    localparam logic [3:0] GAP_LAST = 4'(PKT_GAP - 1);

    logic [2:0] state;
    logic [7:0] mem [64];
    logic [5:0] count;
    logic [5:0] rd_idx;
    logic [7:0] parity;
    logic [3:0] gap_cnt;
    logic [7:0] parity_tx;
    logic       load_fire;
    logic       start_legal;

    assign ld_full = (count == 6'd63);

    // A start request in IDLE takes priority over a load in the same cycle.
    assign load_fire   = (state == IDLE) && ld_en && !start && !ld_full;
    assign start_legal = (count != 6'd0) && (dest_addr != 2'd3);

`ifdef ROUTER_TX_BAD_PARITY_EN
    assign parity_tx = corrupt_parity ? ~parity : parity;
`else
    assign parity_tx = parity;
`endif

    // The payload buffer has no reset. Reset only clears count, which marks
    // every entry as stale.
    always_ff @(posedge clock) begin
        if (load_fire) begin
            mem[count] <= ld_data;
        end
    end

    // Each byte is presented one cycle after the FSM decides to send it.
    // Parity accumulates as each byte is presented, so on entry to PAR the
    // register already covers the header and every payload byte.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            count     <= 6'd0;
            rd_idx    <= 6'd0;
            parity    <= 8'd0;
            gap_cnt   <= 4'd0;
            data_out  <= 8'd0;
            pkt_valid <= 1'b0;
            tx_active <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (start_legal) begin
                            state     <= HDR;
                            data_out  <= {count, dest_addr};
                            parity    <= {count, dest_addr};
                            pkt_valid <= 1'b1;
                            tx_active <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end else if (load_fire) begin
                        count <= count + 6'd1;
                    end
                end
                HDR: begin
                    if (!busy) begin
                        state    <= PLD;
                        data_out <= mem[0];
                        parity   <= parity ^ mem[0];
                        rd_idx   <= 6'd1;
                    end
                end
                PLD: begin
                    if (!busy) begin
                        if (rd_idx < count) begin
                            data_out <= mem[rd_idx];
                            parity   <= parity ^ mem[rd_idx];
                            rd_idx   <= rd_idx + 6'd1;
                        end else begin
                            state     <= PAR;
                            data_out  <= parity_tx;
                            pkt_valid <= 1'b0;
                        end
                    end
                end
                PAR: begin
                    if (!busy) begin
                        state     <= GAP;
                        done      <= 1'b1;
                        tx_active <= 1'b0;
                        data_out  <= 8'd0;
                        count     <= 6'd0;
                        rd_idx    <= 6'd0;
                        parity    <= 8'd0;
                        gap_cnt   <= 4'd0;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state   <= IDLE;
                        gap_cnt <= 4'd0;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
